// File: rtl/commit_trace_buffer_pkg.sv
// Shared types for the retire-trace capture block: the captured entry layout and the capture FSM states.
// Entry width is fixed here so the RAM, the top level and any software decoder agree on one layout.
package trace_pkg;

  localparam int XLEN  = 32;
  localparam int CYC_W = 16;

  typedef struct packed {
    logic [CYC_W-1:0] cyc;
    logic [XLEN-1:0]  pc;
    logic [31:0]      inst;
    logic [4:0]       rd;
    logic             wen;
    logic [XLEN-1:0]  data;
  } trace_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    POST   = 2'd2,
    FROZEN = 2'd3
  } trace_state_e;

endpackage

// File: rtl/commit_trace_buffer_ram.sv
// Trace storage: one write port, one registered read port, read-first on an address collision.
// Read data appears one clock after re_i; no reset, contents are meaningless until written.
module trace_ram
  import trace_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         we_i,
  input  logic [AW-1:0] waddr_i,
  input  trace_entry_t wdata_i,
  input  logic         re_i,
  input  logic [AW-1:0] raddr_i,
  output trace_entry_t rdata_o
);

  trace_entry_t mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Retire-trace capture beside writeback: circular buffer of retired instructions with optional PC trigger.
// Capture is single-cycle and never stalls the pipeline; readback has one cycle of latency.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             retire_valid,
  input  logic [XLEN-1:0]  retire_pc,
  input  logic [31:0]      retire_inst,
  input  logic [4:0]       retire_rd,
  input  logic             retire_wen,
  input  logic [XLEN-1:0]  retire_data,
  input  logic             arm,
  input  logic             mode,
  input  logic [XLEN-1:0]  trig_pc,
  input  logic [IDX_W-1:0] post_cnt,
  input  logic             rd_req,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic             rd_err,
  output trace_entry_t     rd_entry,
  output logic [1:0]       state,
  output logic [IDX_W:0]   count,
  output logic             overflow,
  output logic             triggered
);

  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

  trace_state_e     state_q, state_d;
  logic [IDX_W-1:0] wr_ptr_q;
  logic [IDX_W:0]   count_q;
  logic             overflow_q, triggered_q;
  logic             mode_q;
  logic [XLEN-1:0]  trig_pc_q;
  logic [IDX_W-1:0] post_cnt_q, post_q;
  logic [CYC_W-1:0] cyc_q;
  logic             rd_valid_q, rd_err_q;

  logic             capture;
  logic             fire;
  logic             rd_oob;
  logic [IDX_W-1:0] rd_addr;
  trace_entry_t     wr_entry;
  trace_entry_t     ram_rdata;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // arm wins over everything, including a trigger hit in the same cycle
  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        ARMED:   if (fire && mode_q) state_d = (post_cnt_q == '0) ? FROZEN : POST;
        POST:    if (capture && post_q == IDX_W'(1)) state_d = FROZEN;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    capture = 1'b0;
    fire    = 1'b0;
    if (!arm && retire_valid && (state_q == ARMED || state_q == POST)) begin
      capture = 1'b1;
      fire    = (state_q == ARMED) && (retire_pc == trig_pc_q);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      triggered_q <= 1'b0;
      mode_q      <= 1'b0;
      trig_pc_q   <= '0;
      post_cnt_q  <= '0;
      post_q      <= '0;
    end else if (arm) begin
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      triggered_q <= 1'b0;
      mode_q      <= mode;
      trig_pc_q   <= trig_pc;
      post_cnt_q  <= post_cnt;
    end else if (capture) begin
      wr_ptr_q <= wr_ptr_q + IDX_W'(1);
      if (count_q == FULL_CNT) overflow_q <= 1'b1;
      else                     count_q    <= count_q + (IDX_W+1)'(1);
      if (fire) begin
        triggered_q <= 1'b1;
        post_q      <= post_cnt_q;
      end else if (state_q == POST) begin
        post_q <= post_q - IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc_q <= '0;
    else          cyc_q <= cyc_q + CYC_W'(1);
  end

  assign wr_entry = '{cyc: cyc_q, pc: retire_pc, inst: retire_inst, rd: retire_rd,
                      wen: retire_wen, data: retire_data};

  // once the buffer has wrapped, the oldest entry sits at the write pointer
  assign rd_oob  = {1'b0, rd_idx} >= count_q;
  assign rd_addr = ((count_q == FULL_CNT) ? wr_ptr_q : '0) + rd_idx;

  trace_ram #(.DEPTH(DEPTH)) u_ram (
    .clk_i   (clock),
    .we_i    (capture),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .re_i    (rd_req),
    .raddr_i (rd_addr),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_req;
      rd_err_q   <= rd_req && rd_oob;
    end
  end

  // RAM has no reset, so the output is gated to keep reset and error reads at zero
  assign rd_entry  = (rd_valid_q && !rd_err_q) ? ram_rdata : trace_entry_t'('0);
  assign rd_valid  = rd_valid_q;
  assign rd_err    = rd_err_q;
  assign state     = state_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign triggered = triggered_q;

endmodule
